vga_timing_gen: RTL and testbench

Raster timing generator for the 640x480@60 display path, clocked from the ~25.175 MHz pixel clock (`clk0_out`) produced by the pixel PLL. It gates on the PLL lock indicator and produces sync, data-enable and pixel coordinates. The Mandelbrot pixel engine and framebuffer read port consume `x`/`y` early; the delayed `hsync`/`vsync`/`de` align with that consumer's `PIPE_LAG`-cycle latency at the video pins.

---
 rtl/vga_timing_pkg.sv | 55 +++++
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the raster timing generator.
// Default geometry is 640x480@60 on a ~25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_t;

  // Asserted-level flags; polarity is applied at the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vid_flags_t;

  function automatic int total_len(
    input int act, input int fp,
    input int sw, input int bp
  );
    return act + fp + sw + bp;
  endfunction

  function automatic int sync_start(
    input int act, input int fp
  );
    return act + fp;
  endfunction

  function automatic int sync_end(
    input int act, input int fp, input int sw
  );
    return act + fp + sw - 1;
  endfunction

  localparam int DEF_H_TOTAL = total_len(DEF_H_ACTIVE,
    DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = total_len(DEF_V_ACTIVE,
    DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the generator to the pixel pipeline.
// master drives coordinates, pulses, syncs, de and running.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t x;
  coord_t y;
  logic   de_early;
  logic   frame_start;
  logic   line_start;
  logic   hsync;
  logic   vsync;
  logic   de;
  logic   running;

  modport master (
    output x, y, de_early,
    output frame_start, line_start,
    output hsync, vsync, de, running
  );

  modport slave (
    input x, y, de_early,
    input frame_start, line_start,
    input hsync, vsync, de, running
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async level), q (synchronized level).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator gated by PLL lock; drives vid bundle.
// Ports: clk, rst_n, pll_lock (async), vid (vga_timing_gen_if.master).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_LAG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL =
    total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG =
    coord_t'(sync_start(H_ACTIVE, H_FP));
  localparam coord_t HS_END =
    coord_t'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam coord_t VS_BEG =
    coord_t'(sync_start(V_ACTIVE, V_FP));
  localparam coord_t VS_END =
    coord_t'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
    end
    if (PIPE_LAG < 0 || PIPE_LAG > 7) begin : g_bad_lag
      $error("vga_timing_gen: PIPE_LAG must be 0..7");
    end
  endgenerate

  logic running;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (running)
  );

  run_state_t state_q, state_n;
  logic       active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // RUN is entered one cycle after running rises, so (0,0) is
  // presented the cycle after the synchronizer output goes high.
  // Losing running drops active in the same cycle.
  always_comb begin
    state_n = state_q;
    active  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (running) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (running) active  = 1'b1;
        else         state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  coord_t     x_q, y_q;
  coord_t     x_n, y_n;
  logic       fs_q, ls_q;
  vid_flags_t u_q;

  always_comb begin
    x_n = '0;
    y_n = '0;
    if (active) begin
      y_n = y_q;
      if (x_q == H_LAST) begin
        y_n = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_n = x_q + 1'b1;
      end
    end
  end

  // Flags are decoded from the next position so they are
  // registered alongside the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
      ls_q <= 1'b0;
      u_q  <= '0;
    end else begin
      x_q    <= x_n;
      y_q    <= y_n;
      ls_q   <= (x_n == '0);
      fs_q   <= (x_n == '0) && (y_n == '0);
      u_q.de <= (x_n < H_ACT) && (y_n < V_ACT);
      u_q.hs <= (x_n >= HS_BEG) && (x_n <= HS_END);
      u_q.vs <= (y_n >= VS_BEG) && (y_n <= VS_END);
    end
  end

  vid_flags_t now_f;
  vid_flags_t dly_f;

  assign now_f = active ? u_q : '0;

  generate
    if (PIPE_LAG == 0) begin : g_nolag
      assign dly_f = now_f;
    end else begin : g_lag
      vid_flags_t pipe [PIPE_LAG];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_LAG; i++) pipe[i] <= '0;
        end else if (!active) begin
          for (int i = 0; i < PIPE_LAG; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= now_f;
          for (int i = 1; i < PIPE_LAG; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly_f = active ? pipe[PIPE_LAG-1] : '0;
    end
  endgenerate

  assign vid.x           = active ? x_q : '0;
  assign vid.y           = active ? y_q : '0;
  assign vid.de_early    = now_f.de;
  assign vid.frame_start = active & fs_q;
  assign vid.line_start  = active & ls_q;
  assign vid.hsync       = dly_f.hs ? SYNC_POL : ~SYNC_POL;
  assign vid.vsync       = dly_f.vs ? SYNC_POL : ~SYNC_POL;
  assign vid.de          = dly_f.de;
  assign vid.running     = running;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full 640x480 instance (lag 0) and a small
// geometry instance (lag 2, active-high sync) share lock/reset.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    bit pol; int lag;
  } geo_t;

  localparam geo_t G0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 0};
  localparam geo_t G1 = '{16, 4, 6, 6, 8, 2, 2, 3, 1'b1, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_lock = 1'b0;

  always #20 clk = ~clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();

  vga_timing_gen #(.PIPE_LAG(0)) u_full (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .vid      (if0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .PIPE_LAG(2)
  ) u_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .vid      (if1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: lock synchronizer, run cycle count, histories.
  bit   m_s1, m_run, m_prev, m_act;
  int   rc;
  logic [2:0] hist [2][8];
  logic [26:0] sb0 [$];
  logic [26:0] sb1 [$];

  int  cyc = 0;
  bit  meas = 1'b0;
  int  last_fs = -1, last_ls = -1;
  int  hs_cnt = 0, de_cnt = 0;

  task automatic model_reset();
    m_s1 = 0; m_run = 0; m_prev = 0; m_act = 0; rc = 0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) hist[d][k] = 3'b0;
  endtask

  task automatic model_vec(input geo_t g, input int di,
                           output logic [26:0] v);
    int ht, vt, xx, yy;
    logic ue, uh, uv;
    logic [2:0] d;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    xx = m_act ? rc % ht : 0;
    yy = m_act ? (rc / ht) % vt : 0;
    ue = m_act && xx < g.ha && yy < g.va;
    uh = m_act && xx >= g.ha + g.hfp && xx < g.ha + g.hfp + g.hs;
    uv = m_act && yy >= g.va + g.vfp && yy < g.va + g.vfp + g.vs;
    if (g.lag == 0) d = {uh, uv, ue};
    else d = m_act ? hist[di][g.lag-1] : 3'b0;
    for (int k = 7; k > 0; k--) hist[di][k] = hist[di][k-1];
    hist[di][0] = {uh, uv, ue};
    v = {10'(xx), 10'(yy), ue,
         m_act && xx == 0 && yy == 0, m_act && xx == 0,
         d[2] ? g.pol : !g.pol, d[1] ? g.pol : !g.pol,
         d[0], m_run};
  endtask

  function automatic logic [26:0] obs0();
    return {if0.x, if0.y, if0.de_early, if0.frame_start,
            if0.line_start, if0.hsync, if0.vsync, if0.de,
            if0.running};
  endfunction

  function automatic logic [26:0] obs1();
    return {if1.x, if1.y, if1.de_early, if1.frame_start,
            if1.line_start, if1.hsync, if1.vsync, if1.de,
            if1.running};
  endfunction

  task automatic push_expected();
    logic [26:0] v0, v1;
    model_vec(G0, 0, v0);
    sb0.push_back(v0);
    model_vec(G1, 1, v1);
    sb1.push_back(v1);
  endtask

  task automatic compare(input string t0, input string t1);
    check(t0, 32'(obs0()), 32'(sb0.pop_front()));
    check(t1, 32'(obs1()), 32'(sb1.pop_front()));
  endtask

  task automatic tick();
    bit old_act;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_prev  = m_run;
      m_run   = m_s1;
      m_s1    = pll_lock;
      old_act = m_act;
      m_act   = m_run && m_prev;
      rc      = m_act ? (old_act ? rc + 1 : 0) : 0;
    end
    push_expected();
    #1;
    compare("full", "small");
    if (meas) begin
      if (if0.hsync == 1'b0) hs_cnt++;
      if (if0.de) de_cnt++;
      if (if0.line_start) begin
        if (last_ls >= 0) begin
          check("ls_period", 32'(cyc - last_ls), 32'd800);
          check("hs_width", 32'(hs_cnt), 32'd96);
          check("de_width", 32'(de_cnt), 32'd640);
        end
        last_ls = cyc;
        hs_cnt  = 0;
        de_cnt  = 0;
      end
      if (if1.frame_start) begin
        if (last_fs >= 0)
          check("fs_period", 32'(cyc - last_fs), 32'd480);
        last_fs = cyc;
      end
    end
  endtask

  initial begin
    int  n;
    bit  found;
    model_reset();
    #1;
    rst_n    = 1'b0;
    pll_lock = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!if0.running && n < 10) begin
      tick();
      n++;
    end
    check("run_lat", 32'(n), 32'd2);
    n = 0;
    while (!if0.frame_start && n < 10) begin
      tick();
      n++;
    end
    check("fs_lat", 32'(n), 32'd1);
    check("fs_x", 32'(if0.x), 32'd0);

    meas = 1'b1;
    last_fs = cyc;
    last_ls = -1;
    for (int i = 0; i < 2600; i++) tick();
    meas = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = m_act && (rc % 32) == 10 && ((rc / 32) % 15) == 5;
    end
    check("wait_drop_pos", 32'(found), 32'd1);
    @(negedge clk);
    pll_lock = 1'b0;
    tick();
    tick();
    check("drop_x", 32'(if1.x), 32'd0);
    check("drop_de", 32'(if1.de), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    pll_lock = 1'b1;
    n = 0;
    while (!if1.frame_start && n < 10) begin
      tick();
      n++;
    end
    check("relock_lat", 32'(n), 32'd3);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = m_act && (rc % 800) == 700;
    end
    check("wait_x700", 32'(found), 32'd1);
    check("hs_mid", 32'(if0.hsync), 32'd0);
    #5;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_expected();
    compare("async_full", "async_small");
    check("async_x", 32'(if0.x), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1200; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
